// File: rtl/mem_rr_arbiter_if.sv
// Request, response and memory-side bundle for mem_rr_arbiter.
// The slave modport is the arbiter. The master modport is its environment: the clients and the memory macro.
interface mem_rr_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              mem_chip_en;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  mem_rd_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mem_chip_en, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output mem_rd_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mem_chip_en, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port synchronous memory.
// It issues at most one access per cycle and routes read data back to the requester that issued the read.
module mem_rr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic           clock,
  input  logic           reset,
  mem_rr_arbiter_if.slave bus
);

  logic              w_sel;
  logic              w_acc;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rsp0;
  logic              w_rsp1;

  logic              r_last_grant;
  logic              r_chip_en;
  logic              r_wr_en;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [RD_LAT:0]   r_tag_vld;
  logic [RD_LAT:0]   r_tag_own;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  // Under contention, the requester that did not win last time is granted.
  always_comb begin
    w_sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
    w_acc = ~reset & (bus.req0_valid | bus.req1_valid);
    if (w_sel) begin
      w_write = bus.req1_write;
      w_addr  = bus.req1_addr;
      w_wdata = bus.req1_wdata;
    end else begin
      w_write = bus.req0_write;
      w_addr  = bus.req0_addr;
      w_wdata = bus.req0_wdata;
    end
  end

  assign bus.req0_ready = w_acc & ~w_sel;
  assign bus.req1_ready = w_acc & w_sel;

  // Memory-side registers, read-tag pipeline and held response data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_chip_en    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wr_data    <= {DATA_W{1'b0}};
      r_tag_vld    <= {(RD_LAT+1){1'b0}};
      r_tag_own    <= {(RD_LAT+1){1'b0}};
      r_rdata0     <= {DATA_W{1'b0}};
      r_rdata1     <= {DATA_W{1'b0}};
    end else begin
      r_chip_en <= w_acc;
      r_wr_en   <= w_acc & w_write;
      r_rd_en   <= w_acc & ~w_write;
      if (w_acc) begin
        r_last_grant <= w_sel;
        r_addr       <= w_addr;
        r_wr_data    <= w_wdata;
      end
      r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_acc & ~w_write};
      r_tag_own <= {r_tag_own[RD_LAT-1:0], w_sel};
      if (w_rsp0) begin
        r_rdata0 <= bus.mem_rd_data;
      end
      if (w_rsp1) begin
        r_rdata1 <= bus.mem_rd_data;
      end
    end
  end

  // Gating with reset keeps an access or response that was already in flight
  // from reaching the memory or a client during the reset cycle itself.
  assign w_rsp0 = ~reset & r_tag_vld[RD_LAT] & ~r_tag_own[RD_LAT];
  assign w_rsp1 = ~reset & r_tag_vld[RD_LAT] & r_tag_own[RD_LAT];

  assign bus.rsp0_valid  = w_rsp0;
  assign bus.rsp1_valid  = w_rsp1;
  assign bus.rsp0_rdata  = w_rsp0 ? bus.mem_rd_data : r_rdata0;
  assign bus.rsp1_rdata  = w_rsp1 ? bus.mem_rd_data : r_rdata1;

  assign bus.mem_chip_en = r_chip_en & ~reset;
  assign bus.mem_wr_en   = r_wr_en & ~reset;
  assign bus.mem_rd_en   = r_rd_en & ~reset;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_data = r_wr_data;

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port synchronous memory macro (MemGen_16_10 class: chip_en/wr_en/rd_en/addr/wr_data/rd_data).
- Accepts read/write requests over valid/ready handshakes and issues at most one memory access per cycle through registered memory-side outputs.
- Routes read data back to the requester that issued the read.
- Sits between client blocks and the memory instance in the flat netlist.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 10, memory address width (depth 2**ADDR_W).
- RD_LAT, 1, memory read latency in cycles from the access edge to valid rd_data; must be at least 1.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has a request.
- reqN_ready  out  1  request N is accepted this cycle.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  request address.
- reqN_wdata  in  DATA_W  write data.
- rspN_valid  out  1  one-cycle pulse: read data for requester N is valid.
- rspN_rdata  out  DATA_W  read data for requester N.
- mem_chip_en  out  1  memory chip enable.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data.

Behaviour:
- Interface decision: one clock, named clock; reset is synchronous and active-high, named reset.
- Reset values:
  - reqN_ready=0, rspN_valid=0, rspN_rdata=0.
  - mem_chip_en=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wr_data=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Read-tag pipeline cleared.
- Arbitration (combinational within cycle T):
  - Only req0_valid → grant 0. Only req1_valid → grant 1.
  - Both valid → grant the requester not equal to last_grant.
  - reqN_ready=1 only for the granted requester; at most one ready high per cycle.
  - Ready is never high while reset is high.
  - Acceptance = valid && ready.
  - last_grant updates only on acceptance.
- Request hold rule: requester must hold valid and its fields stable until accepted. The arbiter must tolerate valid dropping before acceptance; it then issues nothing for that requester.
- Issue (registered):
  - Acceptance in cycle T → during T+1: mem_chip_en=1, mem_wr_en=write, mem_rd_en=!write, with mem_addr and mem_wr_data from the winner.
  - No acceptance in T → all three enables low in T+1; addr and wr_data hold their previous values.
- Throughput: one access per cycle, back-to-back, with no bubbles between requesters.
- Starvation: a continuously valid requester is accepted within 2 cycles.
- Read response:
  - A RD_LAT+1 deep tag pipeline (valid plus owner bit) follows each issued read.
  - A read accepted in cycle T gives rspN_valid=1 for exactly cycle T+1+RD_LAT (T+2 at default), with rspN_rdata=mem_rd_data.
  - The non-owner's rsp_valid stays 0; its rsp_rdata holds its previous value.
  - There is no response backpressure: clients must always accept responses.
- Writes produce no response.
- Ordering: accesses reach memory in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped with no rsp_valid. A request presented during reset is not accepted.
- Address and data widths pass through unchanged; no arithmetic on addresses.

Test Plan:
- Reset then idle → all outputs 0; enables stay 0 for 10 cycles.
- req0 write addr=0x005 data=0xBEEF at T, then req0 read addr=0x005 at T+1 → write issued at T+1; rsp0_valid only at T+3 with rsp0_rdata=0xBEEF; rsp1_valid stays 0.
- Both requesters valid for 6 cycles (reads at 0x010 and 0x020) → grants alternate 0,1,0,1,0,1; mem_addr alternates 0x010/0x020 from T+1; rsp owners alternate matching the grants.
- req1 alone for 3 accepts, then req0 joins → req0 is granted on the next contested cycle; no idle cycles on mem_chip_en.
- Read accepted at T, reset asserted at T+1 for 1 cycle → no rsp_valid ever; all mem enables 0 during and after reset until a new acceptance.
- RD_LAT=2 build: read to preloaded addr 0x3FF=0x1234 accepted at T → rsp valid exactly at T+3 with 0x1234.
